// File: rtl/hook_motion_ctrl.sv
// hook_motion_ctrl: per-frame erase/update/draw sequencer for the hook renderer,
// owning the hook's swing, extend and retract motion state.
module hook_motion_ctrl #(
  parameter int DEG_MIN  = 10,
  parameter int DEG_MAX  = 150,
  parameter int DEG_STEP = 2,
  parameter int LEN_MIN  = 20,
  parameter int LEN_MAX  = 200,
  parameter int EXT_STEP = 4,
  parameter int RET_STEP = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic       hit,
  input  logic [1:0] hit_weight,
  input  logic       draw_done,
  output logic       draw_enable,
  output logic       draw_erase,
  output logic [8:0] degree,
  output logic [9:0] length,
  output logic       busy,
  output logic       overrun,
  output logic       caught,
  output logic [1:0] motion
);
  typedef enum logic [2:0] {R_WAIT, R_ERASE, R_ERASE_WAIT, R_UPDATE, R_DRAW, R_DRAW_WAIT} rstate_t;
  localparam logic [1:0] SWING = 2'd0, EXTEND = 2'd1, RETRACT = 2'd2;
  rstate_t state, state_n;
  logic dir, load, fire_l, hit_l, upd;
  logic [1:0] weight, motion_n;
  logic [8:0] degree_n;
  logic [9:0] length_n, ret_sh, ret_step;
  logic [10:0] deg_up, len_ext;
  logic dir_n, load_n, caught_n;
  always_ff @(posedge clock) begin
    if (reset) state <= R_WAIT;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      R_WAIT:       state_n = frame_tick ? R_ERASE : R_WAIT;
      R_ERASE:      state_n = R_ERASE_WAIT;
      R_ERASE_WAIT: state_n = draw_done ? R_UPDATE : R_ERASE_WAIT;
      R_UPDATE:     state_n = R_DRAW;
      R_DRAW:       state_n = R_DRAW_WAIT;
      R_DRAW_WAIT:  state_n = draw_done ? R_WAIT : R_DRAW_WAIT;
      default:      state_n = R_WAIT;
    endcase
  end
  always_comb begin
    draw_enable = state == R_ERASE || state == R_DRAW;
    draw_erase = state == R_ERASE;
    busy = state != R_WAIT;
    upd = state == R_UPDATE;
  end
  // One motion step, committed only while the sequencer sits in R_UPDATE.
  always_comb begin
    degree_n = degree;
    length_n = length;
    motion_n = motion;
    dir_n = dir;
    load_n = load;
    caught_n = 1'b0;
    deg_up = 11'(degree) + 11'(DEG_STEP);
    len_ext = 11'(length) + 11'(EXT_STEP);
    ret_sh = 10'(RET_STEP) >> weight;
    ret_step = !load ? 10'(RET_STEP) : (ret_sh == '0 ? 10'd1 : ret_sh);
    case (motion)
      SWING: begin
        if (fire_l) motion_n = EXTEND;
        else if (!dir) begin
          degree_n = deg_up >= 11'(DEG_MAX) ? 9'(DEG_MAX) : deg_up[8:0];
          dir_n = deg_up >= 11'(DEG_MAX);
        end else begin
          degree_n = 11'(degree) <= 11'(DEG_MIN) + 11'(DEG_STEP) ? 9'(DEG_MIN) : degree - 9'(DEG_STEP);
          dir_n = !(11'(degree) <= 11'(DEG_MIN) + 11'(DEG_STEP));
        end
      end
      EXTEND: begin
        if (hit_l) begin
          motion_n = RETRACT;
          load_n = 1'b1;
        end else if (len_ext >= 11'(LEN_MAX)) begin
          length_n = 10'(LEN_MAX);
          motion_n = RETRACT;
          load_n = 1'b0;
        end else length_n = len_ext[9:0];
      end
      default: begin
        if (11'(length) <= 11'(LEN_MIN) + 11'(ret_step)) begin
          length_n = 10'(LEN_MIN);
          motion_n = SWING;
          caught_n = load;
          load_n = 1'b0;
        end else length_n = length - ret_step;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      degree <= 9'(DEG_MIN);
      length <= 10'(LEN_MIN);
      motion <= SWING;
      dir <= 1'b0;
      load <= 1'b0;
      fire_l <= 1'b0;
      hit_l <= 1'b0;
      weight <= 2'd0;
      caught <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= frame_tick && state != R_WAIT;
      caught <= upd && caught_n;
      if (upd) begin
        degree <= degree_n;
        length <= length_n;
        motion <= motion_n;
        dir <= dir_n;
        load <= load_n;
      end
      // Requests arriving during R_UPDATE survive into the next frame unless the motion changes.
      if (upd && motion_n != motion) begin
        fire_l <= 1'b0;
        hit_l <= 1'b0;
      end else begin
        fire_l <= (fire_l && !upd) || (fire && motion == SWING);
        hit_l <= (hit_l && !upd) || (hit && motion == EXTEND);
        if (hit && motion == EXTEND && (!hit_l || upd)) weight <= hit_weight;
      end
    end
  end
endmodule

// File: tb/tb_hook_motion_ctrl.sv
// tb_hook_motion_ctrl: frame-level randomized bench for hook_motion_ctrl
// with a behavioural per-frame motion model.
module tb_hook_motion_ctrl;
  logic clock = 1'b0, reset = 1'b1, frame_tick = 1'b0, fire = 1'b0, hit = 1'b0, draw_done = 1'b0;
  logic [1:0] hit_weight = 2'd0;
  logic draw_enable, draw_erase, busy, overrun, caught;
  logic [8:0] degree;
  logic [9:0] length;
  logic [1:0] motion;
  int checks = 0, errors = 0;
  int n_en = 0, n_er = 0, n_ov = 0, n_ca = 0;
  int m_deg, m_dir, m_len, m_mot, m_load, m_w;

  hook_motion_ctrl dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .fire(fire), .hit(hit),
    .hit_weight(hit_weight), .draw_done(draw_done), .draw_enable(draw_enable),
    .draw_erase(draw_erase), .degree(degree), .length(length), .busy(busy),
    .overrun(overrun), .caught(caught), .motion(motion)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (draw_enable === 1'b1) n_en++;
    if (draw_enable === 1'b1 && draw_erase === 1'b1) n_er++;
    if (overrun === 1'b1) n_ov++;
    if (caught === 1'b1) n_ca++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_deg = 10; m_dir = 1; m_len = 20; m_mot = 0; m_load = 0; m_w = 0;
  endtask

  // Whole-frame effect of the motion rules; ec is the expected number of caught pulses.
  task automatic model_step(input bit f, input bit h, input int w, output int ec);
    int st;
    ec = 0;
    if (m_mot == 0) begin
      if (f) m_mot = 1;
      else begin
        m_deg += 2 * m_dir;
        if (m_deg >= 150) begin m_deg = 150; m_dir = -1; end
        if (m_deg <= 10) begin m_deg = 10; m_dir = 1; end
      end
    end else if (m_mot == 1) begin
      if (h) begin m_mot = 2; m_load = 1; m_w = w; end
      else if (m_len + 4 >= 200) begin m_len = 200; m_mot = 2; m_load = 0; end
      else m_len += 4;
    end else begin
      st = m_load != 0 ? ((4 >> m_w) > 0 ? (4 >> m_w) : 1) : 4;
      if (m_len - st <= 20) begin m_len = 20; m_mot = 0; ec = m_load; m_load = 0; end
      else m_len -= st;
    end
  endtask

  task automatic do_frame(input bit f, input bit h, input logic [1:0] w, input bit dbl);
    int e0, r0, o0, c0, ec, d;
    e0 = n_en; r0 = n_er; o0 = n_ov; c0 = n_ca;
    d = $urandom_range(2, 6);
    fire = f;
    frame_tick = 1'b1;
    @(negedge clock);
    fire = 1'b0;
    frame_tick = 1'b0;
    chk("erase_en", draw_enable, 1);
    chk("erase_flag", draw_erase, 1);
    chk("busy_mid", busy, 1);
    chk("old_deg", degree, m_deg);
    chk("old_len", length, m_len);
    hit = h;
    hit_weight = w;
    for (int i = 0; i < d; i++) begin
      @(negedge clock);
      frame_tick = dbl && i == 0;
    end
    frame_tick = 1'b0;
    draw_done = 1'b1;
    model_step(f, h && m_mot == 1, int'(w), ec);
    @(negedge clock);
    draw_done = 1'b0;
    hit = 1'b0;
    @(negedge clock);
    chk("draw_en", draw_enable, 1);
    chk("draw_flag", draw_erase, 0);
    chk("new_deg", degree, m_deg);
    chk("new_len", length, m_len);
    chk("motion", motion, m_mot);
    d = $urandom_range(1, 6);
    repeat (d) @(negedge clock);
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    chk("busy_end", busy, 0);
    chk("n_enable", n_en - e0, 2);
    chk("n_erase", n_er - r0, 1);
    chk("n_overrun", n_ov - o0, dbl);
    chk("n_caught", n_ca - c0, ec);
  endtask

  initial begin
    int frames, c0, e0, peak;
    logic [8:0] od;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    e0 = n_en;
    repeat (10) @(negedge clock);
    chk("rst_deg", degree, 10);
    chk("rst_len", length, 20);
    chk("rst_motion", motion, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_caught", caught, 0);
    chk("rst_erase", draw_erase, 0);
    chk("idle_enables", n_en - e0, 0);

    for (int k = 1; k <= 71; k++) begin
      do_frame(1'b0, 1'b0, 2'd0, 1'b0);
      if (k == 70) chk("deg_f70", degree, 150);
      if (k == 71) chk("deg_f71", degree, 148);
    end

    od = degree;
    c0 = n_ca;
    do_frame(1'b1, 1'b0, 2'd0, 1'b0);
    chk("fire_motion", motion, 1);
    frames = 0;
    peak = 0;
    while (m_mot != 0 && frames < 200) begin
      do_frame(1'b0, 1'b0, 2'd0, 1'b0);
      if (int'(length) > peak) peak = int'(length);
      frames++;
    end
    chk("miss_frames", frames, 90);
    chk("miss_peak", peak, 200);
    chk("miss_deg", degree, od);
    chk("miss_caught", n_ca - c0, 0);

    c0 = n_ca;
    do_frame(1'b1, 1'b0, 2'd0, 1'b0);
    frames = 0;
    while (m_len < 60 && frames < 100) begin
      do_frame(1'b0, 1'b0, 2'd0, 1'b0);
      frames++;
    end
    do_frame(1'b0, 1'b1, 2'd2, 1'b0);
    chk("hit_motion", motion, 2);
    chk("hit_len", length, 60);
    frames = 0;
    while (m_mot != 0 && frames < 200) begin
      do_frame(1'b0, 1'b0, 2'd0, 1'b0);
      frames++;
    end
    chk("hit_frames", frames, 40);
    chk("hit_caught", n_ca - c0, 1);
    chk("hit_home", motion, 0);

    do_frame(1'b0, 1'b0, 2'd0, 1'b1);

    for (int k = 0; k < 120; k++)
      do_frame($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);

    frames = 0;
    while (m_mot != 0 && frames < 200) begin
      do_frame(1'b0, 1'b0, 2'd0, 1'b0);
      frames++;
    end
    do_frame(1'b1, 1'b0, 2'd0, 1'b0);
    do_frame(1'b0, 1'b0, 2'd0, 1'b0);
    e0 = n_en;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    repeat (2) @(negedge clock);
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    repeat (2) @(negedge clock);
    chk("pre_rst_motion", motion, 1);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_len", length, 20);
    chk("mid_rst_motion", motion, 0);
    chk("mid_rst_deg", degree, 10);
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    repeat (3) @(negedge clock);
    chk("late_done_busy", busy, 0);
    chk("late_done_enables", n_en - e0, 2);
    do_frame(1'b0, 1'b0, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
